// File: rtl/inv_sub_bytes_seq.sv
// Iterative AES InvSubBytes engine: applies the inverse S-box to a 128-bit state,
// BYTES_PER_CYCLE bytes per clock, with valid/ready handshakes on both sides.
module inv_sub_bytes_seq #(
    parameter int unsigned BYTES_PER_CYCLE = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int unsigned NUM_STEPS   = 16 / BYTES_PER_CYCLE;
    localparam int unsigned STEP_W      = 4;
    localparam int unsigned OFF_W       = 7;
    localparam int unsigned CHUNK_SHIFT = $clog2(BYTES_PER_CYCLE) + 3;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Only power-of-two lane counts divide the 16-byte state evenly.
    if (BYTES_PER_CYCLE != 1 && BYTES_PER_CYCLE != 2 && BYTES_PER_CYCLE != 4 &&
        BYTES_PER_CYCLE != 8 && BYTES_PER_CYCLE != 16) begin : g_bad_cfg
        $error("inv_sub_bytes_seq: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [127:0]        data_q, data_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q, busy_d;

    logic [OFF_W-1:0]    chunk_base;
    logic [OFF_W-1:0]    lane_off [BYTES_PER_CYCLE];
    logic [7:0]          lane_in  [BYTES_PER_CYCLE];
    logic [7:0]          lane_out [BYTES_PER_CYCLE];

    assign chunk_base = OFF_W'(step_q) << CHUNK_SHIFT;

    // One inverse S-box per lane; lane g reads byte step*BPC+g.
    for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_lane
        assign lane_off[g] = chunk_base + OFF_W'(g * 8);
        assign lane_in[g]  = data_q[lane_off[g] +: 8];
        assign lane_out[g] = INV_SBOX[lane_in[g]];
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        step_d  = step_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    step_d  = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                for (int unsigned i = 0; i < BYTES_PER_CYCLE; i++) begin
                    data_d[lane_off[i] +: 8] = lane_out[i];
                end
                if (step_q == LAST_STEP) begin
                    step_d  = '0;
                    state_d = DONE;
                end else begin
                    step_d = step_q + STEP_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            data_q      <= '0;
            step_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            step_q      <= step_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Directed self-checking bench for inv_sub_bytes_seq across all lane counts.
module tb_inv_sub_bytes_seq;

    localparam int unsigned N = 4;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, out_ready;
    logic [127:0] in_data;
    logic         in_ready, out_valid, busy;
    logic [127:0] out_data;

    logic         p_in_valid;
    logic [127:0] p_in_data;
    logic         p_out_ready;
    logic [4:0]   p_in_ready, p_out_valid, p_busy;
    logic [127:0] p_out_data [5];

    logic [7:0]   inv_ref [256];
    int           tests = 0;
    int           fails = 0;

    always #5 clk = ~clk;

    inv_sub_bytes_seq #(.BYTES_PER_CYCLE(N)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    for (genvar g = 0; g < 5; g++) begin : g_par
        inv_sub_bytes_seq #(.BYTES_PER_CYCLE(1 << g)) u_p (
            .clk(clk), .rst(rst), .in_valid(p_in_valid), .in_ready(p_in_ready[g]),
            .in_data(p_in_data), .out_valid(p_out_valid[g]), .out_ready(p_out_ready),
            .out_data(p_out_data[g]), .busy(p_busy[g])
        );
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] ref_inv(input logic [127:0] d);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = inv_ref[d[8*k +: 8]];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One block through u_dut with out_ready high; checks latency, data and status.
    task automatic run_block(input logic [127:0] d, input logic [127:0] exp, input string tag);
        int  n   = 0;
        int  lat = 0;
        bit  bad = 1'b0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check({tag, " ready"}, 128'(in_ready), 128'(1));
        in_valid  = 1'b1;
        in_data   = d;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        in_data  = 'x;
        while (!out_valid && lat < 40) begin
            if (in_ready || !busy) bad = 1'b1;
            tick();
            lat++;
        end
        check({tag, " latency"}, 128'(lat), 128'(N));
        check({tag, " data"}, out_data, exp);
        check({tag, " ready low while busy"}, 128'(bad), 128'(0));
        tick();
    endtask

    // Same block through every lane-count instance in parallel.
    task automatic run_param(input logic [127:0] d, input logic [127:0] exp, input string tag);
        int           lat [5];
        logic [127:0] got [5];
        bit           seen [5];
        int           n = 0;
        for (int g = 0; g < 5; g++) begin
            lat[g] = 0; got[g] = '0; seen[g] = 1'b0;
        end
        while (p_in_ready != 5'h1f && n < 50) begin
            tick();
            n++;
        end
        p_in_valid = 1'b1;
        p_in_data  = d;
        tick();
        p_in_valid = 1'b0;
        p_in_data  = 'x;
        for (int c = 1; c <= 20; c++) begin
            tick();
            for (int g = 0; g < 5; g++) begin
                if (!seen[g] && p_out_valid[g]) begin
                    seen[g] = 1'b1;
                    lat[g]  = c;
                    got[g]  = p_out_data[g];
                end
            end
        end
        for (int g = 0; g < 5; g++) begin
            check($sformatf("%s bpc%0d latency", tag, 1 << g), 128'(lat[g]), 128'(16 >> g));
            check($sformatf("%s bpc%0d data", tag, 1 << g), got[g], exp);
        end
    endtask

    initial begin
        logic [127:0] d, exp, a, b;
        logic [127:0] outs [2];
        int           acc_cyc [2];
        int           n_acc, n_out, lat;
        bit           acc, stale;

        for (int x = 0; x < 256; x++) inv_ref[SBOX[x]] = 8'(x);

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        p_in_valid = 1'b0; p_in_data = '0; p_out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("reset in_ready", 128'(in_ready), 128'(1));
        check("reset out_valid", 128'(out_valid), 128'(0));
        check("reset busy", 128'(busy), 128'(0));
        check("reset out_data", out_data, 128'(0));
        check("reset param busy", 128'(p_busy), 128'(0));

        run_block(128'h637c777bf26b6fc53001672bfed7ab76, 128'h000102030405060708090a0b0c0d0e0f, "row0");

        run_param({16{8'h63}}, {16{8'h00}}, "uni63");
        run_param({16{8'h00}}, {16{8'h52}}, "uni00");
        run_param({16{8'h16}}, {16{8'hff}}, "uni16");
        run_param({16{8'hed}}, {16{8'h53}}, "unied");

        for (int x = 0; x < 256; x++) begin
            run_block({16{SBOX[x]}}, {16{8'(x)}}, $sformatf("rt%0d", x));
        end

        for (int r = 0; r < 1000; r++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            run_block(d, ref_inv(d), $sformatf("rnd%0d", r));
        end

        // Backpressure: hold out_ready low with noise on the input side.
        d   = 128'h0123456789abcdeffedcba9876543210;
        exp = ref_inv(d);
        in_valid = 1'b1; in_data = d; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check("bp latency", 128'(lat), 128'(N));
        for (int i = 0; i < 10; i++) begin
            check($sformatf("bp data c%0d", i), out_data, exp);
            check($sformatf("bp status c%0d", i), {126'(0), out_valid, in_ready}, 128'(2'b10));
            in_valid = 1'(i);
            in_data  = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp release", {126'(0), out_valid, in_ready}, 128'(2'b01));

        // Reset while at step 2 of a block.
        in_valid = 1'b1; in_data = {16{8'h63}};
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst status", {125'(0), out_valid, in_ready, busy}, 128'(3'b010));
        check("midrst out_data", out_data, 128'(0));
        stale = 1'b0;
        for (int i = 0; i < N + 2; i++) begin
            if (out_valid) stale = 1'b1;
            tick();
        end
        check("midrst no stale output", 128'(stale), 128'(0));
        run_block({16{8'h16}}, {16{8'hff}}, "post-reset");

        // Back-to-back with in_valid held high.
        a = 128'h00112233445566778899aabbccddeeff;
        b = 128'hdeadbeefcafef00d0badc0de13579bdf;
        outs[0] = '0; outs[1] = '0; acc_cyc[0] = 0; acc_cyc[1] = 0;
        n_acc = 0; n_out = 0;
        in_valid = 1'b1; in_data = a; out_ready = 1'b1;
        for (int i = 0; i < 40 && n_out < 2; i++) begin
            acc = in_valid && in_ready;
            if (out_valid) begin
                outs[n_out] = out_data;
                n_out++;
            end
            tick();
            if (acc && n_acc < 2) begin
                acc_cyc[n_acc] = i;
                n_acc++;
                if (n_acc == 1) in_data = b;
                else begin
                    in_valid = 1'b0;
                    in_data  = 'x;
                end
            end
        end
        in_valid = 1'b0;
        check("b2b outputs", 128'(n_out), 128'(2));
        check("b2b accepts", 128'(n_acc), 128'(2));
        check("b2b first", outs[0], ref_inv(a));
        check("b2b second", outs[1], ref_inv(b));
        check("b2b accept spacing", 128'(acc_cyc[1] - acc_cyc[0]), 128'(N + 2));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
